// File: rtl/riscv_pkg.sv
// Shared RV64 encodings and MEM-stage types: opcodes, load/store func3 values,
// the MEM handshake state type and small decode helpers.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  localparam logic [2:0] F3_SD  = 3'd3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Byte mask for an access size code (func3[1:0]): B, H, W, D.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Valid load or store encoding; unused func3 values decode as no-ops.
  function automatic logic is_ldst(input logic [31:0] ir);
    return ((ir[6:0] == OP_LOAD)  && (ir[14:12] != 3'd7)) ||
           ((ir[6:0] == OP_STORE) && (ir[14:12] <  3'd4));
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus driven by the MEM stage.
interface memory_stage_if;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [63:0] DMEM_ADDR;
  logic [7:0]  DMEM_BE;
  logic [63:0] DMEM_WDATA;
  logic        DMEM_ACK;
  logic [63:0] DMEM_RDATA;

  modport master (
    output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA,
    input  DMEM_ACK, DMEM_RDATA
  );

  modport slave (
    input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA,
    output DMEM_ACK, DMEM_RDATA
  );
endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for the MEM stage: byte enables, store data lane shift
// and load extraction with sign/zero extension. Lanes shifted past the
// doubleword boundary are simply dropped.
// Optional: MEM_MISALIGN_TRAP_EN adds the size-alignment check output.
module mem_align
  import riscv_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [2:0]  offset,
  input  logic [63:0] sr2,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata,
  output logic [63:0] ld_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  logic [63:0] shifted;

  // Lane steering and load extension.
  always_comb begin
    be      = size_mask(func3[1:0]) << offset;
    wdata   = sr2 << {offset, 3'b000};
    shifted = rdata >> {offset, 3'b000};
    case (func3[1:0])
      2'd0:    ld_data = func3[2] ? {56'b0, shifted[7:0]}
                                  : {{56{shifted[7]}}, shifted[7:0]};
      2'd1:    ld_data = func3[2] ? {48'b0, shifted[15:0]}
                                  : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    ld_data = func3[2] ? {32'b0, shifted[31:0]}
                                  : {{32{shifted[31]}}, shifted[31:0]};
      default: ld_data = shifted;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Address not a multiple of the access size.
  always_comb begin
    case (func3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = offset[0];
      2'd2:    misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase
  end
`endif

endmodule

// File: rtl/memory_stage.sv
// RV64 MEM pipeline stage: REQ/ACK data-memory access for loads/stores with a
// stall back to execute, one-cycle pass-through for everything else, and the
// WB latch. TIMEOUT_CYC bounds the WAIT phase (0 disables the timeout).
// Optional: MEM_MISALIGN_TRAP_EN traps misaligned accesses via WB_MISALIGN.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        MEM_V,
  input  logic [31:0] MEM_IR,
  input  logic [63:0] MEM_NPC,
  input  logic [63:0] MEM_ALU_RESULT,
  input  logic [63:0] MEM_SR2,
  input  logic [63:0] MEM_CSRFD,
  input  logic [63:0] MEM_RFD,
  input  logic        MEM_ECALL,
  output logic        V_MEM_STALL,
  memory_stage_if.master dmem,
  output logic        WB_V,
  output logic [31:0] WB_IR,
  output logic [63:0] WB_NPC,
  output logic [63:0] WB_ALU_RESULT,
  output logic [63:0] WB_MEM_DATA,
  output logic [63:0] WB_CSRFD,
  output logic [63:0] WB_RFD,
  output logic        WB_ECALL,
  output logic        WB_BUS_ERR
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        WB_MISALIGN
`endif
);

  mem_state_t  state, state_nxt;
  logic [31:0] to_cnt;
  logic        ldst, memop, is_load, timeout, acked, timed_out;
  logic [7:0]  be;
  logic [63:0] wdata, ld_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  mem_align u_align (
    .func3   (MEM_IR[14:12]),
    .offset  (MEM_ALU_RESULT[2:0]),
    .sr2     (MEM_SR2),
    .rdata   (dmem.DMEM_RDATA),
    .be      (be),
    .wdata   (wdata),
    .ld_data (ld_data)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misaligned (misaligned)
`endif
  );

  // Decode: does the MEM latch hold a valid access that needs the bus.
  always_comb begin
    ldst    = MEM_V & is_ldst(MEM_IR);
    is_load = (MEM_IR[6:0] == OP_LOAD);
`ifdef MEM_MISALIGN_TRAP_EN
    memop   = ldst & ~misaligned;
`else
    memop   = ldst;
`endif
    timeout = (state == WAIT) && (TIMEOUT_CYC != 0) &&
              (to_cnt == 32'(TIMEOUT_CYC - 1));
  end

  // Bus fields come straight from the held MEM latch, so they stay stable in WAIT.
  assign dmem.DMEM_WE    = (MEM_IR[6:0] == OP_STORE);
  assign dmem.DMEM_ADDR  = {MEM_ALU_RESULT[63:3], 3'b000};
  assign dmem.DMEM_BE    = be;
  assign dmem.DMEM_WDATA = wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: IDLE issues the request, WAIT ends on ACK or timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (memop) state_nxt = WAIT;
      WAIT: if (acked | timed_out) state_nxt = IDLE;
    endcase
  end

  // Outputs: request, stall and completion qualifiers; ACK wins over a same-cycle timeout.
  always_comb begin
    dmem.DMEM_REQ = 1'b0;
    V_MEM_STALL   = 1'b0;
    acked         = 1'b0;
    timed_out     = 1'b0;
    if (!RESET) begin
      unique case (state)
        IDLE: begin
          dmem.DMEM_REQ = memop;
          V_MEM_STALL   = memop;
        end
        WAIT: begin
          dmem.DMEM_REQ = 1'b1;
          acked         = dmem.DMEM_ACK;
          timed_out     = ~dmem.DMEM_ACK & timeout;
          V_MEM_STALL   = memop & ~(acked | timed_out);
        end
      endcase
    end
  end

  // Timeout counter: held at zero outside WAIT, counts WAIT cycles.
  always_ff @(posedge clk) begin
    if (RESET || state == IDLE) to_cnt <= '0;
    else                        to_cnt <= to_cnt + 32'd1;
  end

  // WB latch: bubble while stalled, otherwise capture the MEM latch and result.
  always_ff @(posedge clk) begin
    if (RESET) begin
      WB_V          <= 1'b0;
      WB_IR         <= '0;
      WB_NPC        <= '0;
      WB_ALU_RESULT <= '0;
      WB_MEM_DATA   <= '0;
      WB_CSRFD      <= '0;
      WB_RFD        <= '0;
      WB_ECALL      <= 1'b0;
      WB_BUS_ERR    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      WB_MISALIGN   <= 1'b0;
`endif
    end else if (V_MEM_STALL) begin
      WB_V <= 1'b0;
    end else begin
      WB_V          <= MEM_V;
      WB_IR         <= MEM_IR;
      WB_NPC        <= MEM_NPC;
      WB_ALU_RESULT <= MEM_ALU_RESULT;
      WB_MEM_DATA   <= (memop & is_load & acked) ? ld_data : '0;
      WB_CSRFD      <= MEM_CSRFD;
      WB_RFD        <= MEM_RFD;
      WB_ECALL      <= MEM_ECALL;
      WB_BUS_ERR    <= memop & timed_out;
`ifdef MEM_MISALIGN_TRAP_EN
      WB_MISALIGN   <= ldst & misaligned;
`endif
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed cases with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_memory_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        RESET;
  logic        MEM_V;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_NPC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD, MEM_RFD;
  logic        MEM_ECALL;
  logic        V_MEM_STALL;
  logic        WB_V, WB_ECALL, WB_BUS_ERR;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC, WB_ALU_RESULT, WB_MEM_DATA, WB_CSRFD, WB_RFD;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        WB_MISALIGN;
`endif

  always #5 clk = ~clk;

  memory_stage_if dmem ();

  memory_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .RESET(RESET),
    .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_NPC(MEM_NPC),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_SR2(MEM_SR2),
    .MEM_CSRFD(MEM_CSRFD), .MEM_RFD(MEM_RFD), .MEM_ECALL(MEM_ECALL),
    .V_MEM_STALL(V_MEM_STALL), .dmem(dmem),
    .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC), .WB_ALU_RESULT(WB_ALU_RESULT),
    .WB_MEM_DATA(WB_MEM_DATA), .WB_CSRFD(WB_CSRFD), .WB_RFD(WB_RFD),
    .WB_ECALL(WB_ECALL), .WB_BUS_ERR(WB_BUS_ERR)
`ifdef MEM_MISALIGN_TRAP_EN
    , .WB_MISALIGN(WB_MISALIGN)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-level rules) ----------------
  function automatic logic m_ldst(input logic v, input logic [31:0] ir);
    logic [6:0] op;
    logic [2:0] f3;
    op = ir[6:0];
    f3 = ir[14:12];
    return v && ((op == 7'b0000011 && f3 != 3'd7) || (op == 7'b0100011 && f3 < 3'd4));
  endfunction

  function automatic int unsigned m_nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [7:0] m_be(input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] b;
    b = '0;
    for (int unsigned i = 0; i < m_nbytes(f3); i++)
      if (int'(off) + i < 8) b[int'(off) + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] sr2, input logic [2:0] off);
    logic [63:0] w;
    w = '0;
    for (int b = int'(off); b < 8; b++) w[8*b +: 8] = sr2[8*(b - int'(off)) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [2:0] off,
                                          input logic [63:0] rd);
    logic [63:0] v;
    int unsigned n;
    v = '0;
    n = m_nbytes(f3);
    for (int unsigned i = 0; i < n; i++)
      if (int'(off) + i < 8) v[8*i +: 8] = rd[8*(int'(off) + i) +: 8];
    if (!f3[2] && n < 8 && v[8*n - 1])
      for (int unsigned i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic m_misaligned(input logic [2:0] f3, input logic [2:0] off);
    return (int'(off) % m_nbytes(f3)) != 0;
  endfunction

  // Expected WB latch contents after the most recent posedge.
  logic        e_v = 1'b0, e_ecall = 1'b0, e_berr = 1'b0, e_mis = 1'b0;
  logic [31:0] e_ir = '0;
  logic [63:0] e_npc = '0, e_alu = '0, e_md = '0, e_csrfd = '0, e_rfd = '0;
  int unsigned age = 0;  // cycles the current access has already been requesting

  // Per-cycle compare: WB latch, then request/stall/bus fields, then advance model.
  always @(negedge clk) begin : cmp
    logic mo, ldst, ack_ok, tmo, stall_e;
    logic [2:0] off, f3;
    chk("wb_v", WB_V, e_v);
    chk("wb_ir", WB_IR, e_ir);
    chk("wb_npc", WB_NPC, e_npc);
    chk("wb_alu", WB_ALU_RESULT, e_alu);
    chk("wb_mem_data", WB_MEM_DATA, e_md);
    chk("wb_csrfd", WB_CSRFD, e_csrfd);
    chk("wb_rfd", WB_RFD, e_rfd);
    chk("wb_ecall", WB_ECALL, e_ecall);
    chk("wb_bus_err", WB_BUS_ERR, e_berr);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("wb_misalign", WB_MISALIGN, e_mis);
`endif
    off  = MEM_ALU_RESULT[2:0];
    f3   = MEM_IR[14:12];
    ldst = m_ldst(MEM_V, MEM_IR);
`ifdef MEM_MISALIGN_TRAP_EN
    mo = ldst && !m_misaligned(f3, off);
`else
    mo = ldst;
`endif
    ack_ok  = !RESET && mo && age > 0 && dmem.DMEM_ACK;
    tmo     = !RESET && mo && age > 0 && !ack_ok && TO != 0 && age == TO;
    stall_e = !RESET && mo && !(ack_ok || tmo);
    chk("req", dmem.DMEM_REQ, !RESET && mo);
    chk("stall", V_MEM_STALL, stall_e);
    if (!RESET && mo) begin
      chk("we", dmem.DMEM_WE, MEM_IR[6:0] == 7'b0100011);
      chk("addr", dmem.DMEM_ADDR, MEM_ALU_RESULT & ~64'h7);
      chk("be", dmem.DMEM_BE, m_be(f3, off));
      chk("wdata", dmem.DMEM_WDATA, m_wdata(MEM_SR2, off));
    end
    if (RESET) begin
      e_v = 0; e_ir = '0; e_npc = '0; e_alu = '0; e_md = '0;
      e_csrfd = '0; e_rfd = '0; e_ecall = 0; e_berr = 0; e_mis = 0;
    end else if (stall_e) begin
      e_v = 0;
    end else begin
      e_v = MEM_V; e_ir = MEM_IR; e_npc = MEM_NPC; e_alu = MEM_ALU_RESULT;
      e_csrfd = MEM_CSRFD; e_rfd = MEM_RFD; e_ecall = MEM_ECALL;
      e_md   = (ack_ok && MEM_IR[6:0] == 7'b0000011) ? m_load(f3, off, dmem.DMEM_RDATA) : '0;
      e_berr = tmo;
      e_mis  = ldst && m_misaligned(f3, off);
    end
    age = (RESET || !mo || ack_ok || tmo) ? 0 : age + 1;
  end

  // ---------------- stimulus ----------------
  int          req_n;
  logic        stall_seen, we_cap;
  logic [7:0]  be_cap;
  logic [63:0] addr_cap, wd_cap;

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] ir;
    ir = $urandom;
    ir[6:0] = op;
    ir[14:12] = f3;
    return ir;
  endfunction

  // Present one instruction and behave like execute: hold it while stalled.
  // ACK is raised lat cycles after the first request cycle; junk pulses ACK in the request cycle.
  task automatic run_op(input logic v, input logic [31:0] ir, input logic [63:0] alu,
                        input logic [63:0] sr2, input logic [63:0] rdata,
                        input int lat, input logic junk);
    logic st;
    MEM_V = v; MEM_IR = ir; MEM_ALU_RESULT = alu; MEM_SR2 = sr2;
    MEM_NPC = {$urandom, $urandom}; MEM_CSRFD = {$urandom, $urandom};
    MEM_RFD = {$urandom, $urandom}; MEM_ECALL = 1'($urandom);
    req_n = 0;
    stall_seen = 0;
    for (int c = 0; c < 40; c++) begin
      dmem.DMEM_ACK   = (c == lat) || (c == 0 && junk);
      dmem.DMEM_RDATA = (c == lat) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      if (dmem.DMEM_REQ) begin
        if (req_n == 0) begin
          be_cap = dmem.DMEM_BE; addr_cap = dmem.DMEM_ADDR;
          wd_cap = dmem.DMEM_WDATA; we_cap = dmem.DMEM_WE;
        end
        req_n++;
      end
      st = V_MEM_STALL;
      if (st) stall_seen = 1;
      @(posedge clk);
      #1;
      if (!st) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL op_hang: stall still high after 40 cycles, required release");
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat_tab[6] = '{1, 2, 3, 4, 5, 99};
    logic [6:0] op;
    int unsigned k;
    RESET = 1; MEM_V = 0; MEM_IR = '0; MEM_NPC = '0; MEM_ALU_RESULT = '0;
    MEM_SR2 = '0; MEM_CSRFD = '0; MEM_RFD = '0; MEM_ECALL = 0;
    dmem.DMEM_ACK = 0; dmem.DMEM_RDATA = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_v", WB_V, 0);
    chk("rst_wb_mem_data", WB_MEM_DATA, 0);
    chk("rst_req", dmem.DMEM_REQ, 0);
    RESET = 0;

    // ALU pass-through
    run_op(1, mk_ir(7'b0110011, 3'd0), 64'h1234, '0, '0, 1, 0);
    chk("add_req_n", req_n, 0);
    chk("add_stall", stall_seen, 0);
    chk("add_wb_v", WB_V, 1);
    chk("add_wb_alu", WB_ALU_RESULT, 64'h1234);

    // LB at 0x1003
    run_op(1, mk_ir(7'b0000011, 3'd0), 64'h1003, '0, 64'h00000000_80000000, 2, 0);
    chk("lb_req_n", req_n, 3);
    chk("lb_be", be_cap, 8'h08);
    chk("lb_addr", addr_cap, 64'h1000);
    chk("lb_data", WB_MEM_DATA, 64'hFFFFFFFF_FFFFFF80);

    // LHU at 0x2006
    run_op(1, mk_ir(7'b0000011, 3'd5), 64'h2006, '0, 64'hBEEF_0000_0000_0000, 1, 1);
    chk("lhu_be", be_cap, 8'hC0);
    chk("lhu_data", WB_MEM_DATA, 64'h0000_0000_0000_BEEF);

    // SW at 0x3004
    run_op(1, mk_ir(7'b0100011, 3'd2), 64'h3004, 64'h1122_3344_5566_7788, '0, 3, 0);
    chk("sw_we", we_cap, 1);
    chk("sw_be", be_cap, 8'hF0);
    chk("sw_wdata_hi", {32'b0, wd_cap[63:32]}, 64'h5566_7788);
    chk("sw_mem_data", WB_MEM_DATA, 0);

    // LD with ACK never returned
    run_op(1, mk_ir(7'b0000011, 3'd3), 64'h4000, '0, '0, 99, 0);
    chk("to_req_n", req_n, 5);
    chk("to_bus_err", WB_BUS_ERR, 1);
    chk("to_mem_data", WB_MEM_DATA, 0);

    // Reset while waiting for ACK
    MEM_V = 1; MEM_IR = mk_ir(7'b0000011, 3'd2); MEM_ALU_RESULT = 64'h5000;
    dmem.DMEM_ACK = 0;
    repeat (2) begin @(posedge clk); #1; end
    RESET = 1;
    @(negedge clk);
    chk("rstw_req", dmem.DMEM_REQ, 0);
    chk("rstw_stall", V_MEM_STALL, 0);
    @(posedge clk);
    #1;
    chk("rstw_wb_v", WB_V, 0);
    chk("rstw_wb_ir", WB_IR, 0);
    chk("rstw_wb_npc", WB_NPC, 0);
    chk("rstw_wb_bus_err", WB_BUS_ERR, 0);
    MEM_V = 0;
    RESET = 0;
    @(posedge clk);
    #1;

`ifdef MEM_MISALIGN_TRAP_EN
    run_op(1, mk_ir(7'b0000011, 3'd2), 64'h1002, '0, '0, 1, 0);
    chk("mis_req_n", req_n, 0);
    chk("mis_flag", WB_MISALIGN, 1);
`endif

    // Randomized back-to-back traffic
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      if (k < 4)      op = 7'b0000011;
      else if (k < 7) op = 7'b0100011;
      else if (k < 8) op = 7'b0010011;
      else            op = 7'b0110011;
      run_op(($urandom_range(0, 7) != 0), mk_ir(op, 3'($urandom)),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             lat_tab[$urandom_range(0, 5)], 1'($urandom));
    end
    MEM_V = 0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
